// File: rtl/alu_instr_sequencer_pkg.sv
// Shared state encoding and opcode decode helpers for the ALU instruction sequencer.
package minisrc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, ILLEGAL
  } state_t;

  localparam logic [4:0] OPC_ADD = 5'b00011;
  localparam logic [4:0] OPC_SUB = 5'b00100;
  localparam logic [4:0] OPC_AND = 5'b00101;
  localparam logic [4:0] OPC_OR  = 5'b00110;
  localparam logic [4:0] OPC_MUL = 5'b01111;
  localparam logic [4:0] OPC_DIV = 5'b10000;

  function automatic logic is_alu_rr(input logic [4:0] opc);
    return opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_MUL, OPC_DIV};
  endfunction

  // MUL/DIV produce a 64-bit result written back through LO then HI.
  function automatic logic is_hilo(input logic [4:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath it steers (slave).
interface alu_instr_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int NUM_REGS = 16
);
  logic                run;
  logic                step_mode;
  logic                mem_ready;
  logic [DATA_W-1:0]   ir;

  logic                pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
  logic                y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic [OPC_W-1:0]    alu_op;
  logic                busy, done, illegal;

  modport master (
    input  run, step_mode, mem_ready, ir,
    output pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
           reg_in, reg_out, alu_op, busy, done, illegal
  );

  modport slave (
    output run, step_mode, mem_ready, ir,
    input  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
           reg_in, reg_out, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/alu_instr_sequencer_reg_select_decoder.sv
// Register-field to one-hot select decoder; output is all zero when disabled.
// Combinational, no latency; no backpressure.
module reg_select_decoder #(
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                en,
  input  logic [REG_AW-1:0]   sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (sel == REG_AW'(i));
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control FSM for fetch + register-register ALU execute, with MUL/DIV HI/LO write-back.
// Latency: fetch 3 cycles plus memory wait, execute 3 (4 for MUL/DIV); stalls in T1W while mem_ready is low.
module alu_instr_sequencer
  import minisrc_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  alu_instr_sequencer_if.master bus
);

  localparam int FLD_LSB = DATA_W - OPC_W - 3 * REG_AW;
  localparam logic [REG_AW:0] NREGS = (REG_AW + 1)'(NUM_REGS);

  state_t state, state_nxt;

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] ra, rb, rc;
  logic              hilo, legal;
  logic              rout_en, rin_en;
  logic              unused_ir;

  assign opc       = bus.ir[DATA_W-1 -: OPC_W];
  assign ra        = bus.ir[DATA_W-OPC_W-1 -: REG_AW];
  assign rb        = bus.ir[DATA_W-OPC_W-REG_AW-1 -: REG_AW];
  assign rc        = bus.ir[DATA_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign unused_ir = ^bus.ir[FLD_LSB-1:0];

  // Ra is only a destination for single-result ops, so MUL/DIV ignore its range.
  assign hilo  = is_hilo(opc);
  assign legal = is_alu_rr(opc) && ({1'b0, rb} < NREGS) && ({1'b0, rc} < NREGS) &&
                 (hilo || ({1'b0, ra} < NREGS));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.pc_out    = 1'b0;
    bus.mar_in    = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.pc_in     = 1'b0;
    bus.read      = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.ir_in     = 1'b0;
    bus.y_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.zlow_out  = 1'b0;
    bus.zhigh_out = 1'b0;
    bus.lo_in     = 1'b0;
    bus.hi_in     = 1'b0;
    bus.alu_op    = '0;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    case (state)
      IDLE: if (bus.run) state_nxt = T0;
      T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
        state_nxt  = T1;
      end
      T1: begin
        bus.zlow_out = 1'b1;
        bus.pc_in    = 1'b1;
        bus.read     = 1'b1;
        bus.mdr_in   = 1'b1;
        state_nxt    = bus.mem_ready ? T2 : T1W;
      end
      T1W: begin
        bus.read   = 1'b1;
        bus.mdr_in = 1'b1;
        if (bus.mem_ready) state_nxt = T2;
      end
      T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
        state_nxt   = T3;
      end
      T3: begin
        bus.y_in  = legal;
        state_nxt = legal ? T4 : ILLEGAL;
      end
      T4: begin
        bus.alu_op = opc;
        bus.z_in   = 1'b1;
        state_nxt  = T5;
      end
      T5: begin
        bus.zlow_out = 1'b1;
        if (hilo) begin
          bus.lo_in = 1'b1;
          state_nxt = T6;
        end else begin
          bus.done  = 1'b1;
          state_nxt = bus.step_mode ? IDLE : T0;
        end
      end
      T6: begin
        bus.zhigh_out = 1'b1;
        bus.hi_in     = 1'b1;
        bus.done      = 1'b1;
        state_nxt     = bus.step_mode ? IDLE : T0;
      end
      ILLEGAL: begin
        bus.illegal = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // The register bus driver is Rb while Y loads, then Rc while Z loads.
  assign rout_en = ((state == T3) && legal) || (state == T4);
  assign rin_en  = (state == T5) && !hilo;

  reg_select_decoder #(.REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) u_rout_dec (
    .en     (rout_en),
    .sel    ((state == T4) ? rc : rb),
    .onehot (bus.reg_out)
  );

  reg_select_decoder #(.REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (bus.reg_in)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed table-driven bench for alu_instr_sequencer with 16- and 8-register instances.
module tb_alu_instr_sequencer;

  logic        clk, clr;
  logic        run, step_mode, mem_ready, sel8;
  logic [31:0] ir;
  int          n_pass = 0;
  int          n_tot  = 0;
  int          viol   = 0;

  alu_instr_sequencer_if #(.DATA_W(32), .OPC_W(5), .NUM_REGS(16)) b16 ();
  alu_instr_sequencer_if #(.DATA_W(32), .OPC_W(5), .NUM_REGS(8))  b8 ();

  alu_instr_sequencer #(.DATA_W(32), .OPC_W(5), .REG_AW(4), .NUM_REGS(16)) dut16 (
    .clk(clk), .clr(clr), .bus(b16)
  );
  alu_instr_sequencer #(.DATA_W(32), .OPC_W(5), .REG_AW(4), .NUM_REGS(8)) dut8 (
    .clk(clk), .clr(clr), .bus(b8)
  );

  assign b16.run       = run & ~sel8;
  assign b8.run        = run & sel8;
  assign b16.step_mode = step_mode;
  assign b8.step_mode  = step_mode;
  assign b16.mem_ready = mem_ready;
  assign b8.mem_ready  = mem_ready;
  assign b16.ir        = ir;
  assign b8.ir         = ir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] s16, s8, o_strb;
  logic [15:0] o_reg_in, o_reg_out;
  logic [4:0]  o_alu;
  logic        o_busy, o_done, o_illegal;

  assign s16 = {b16.pc_out, b16.mar_in, b16.inc_pc, b16.pc_in, b16.read, b16.mdr_in, b16.mdr_out,
                b16.ir_in, b16.y_in, b16.z_in, b16.zlow_out, b16.zhigh_out, b16.lo_in, b16.hi_in};
  assign s8  = {b8.pc_out, b8.mar_in, b8.inc_pc, b8.pc_in, b8.read, b8.mdr_in, b8.mdr_out,
                b8.ir_in, b8.y_in, b8.z_in, b8.zlow_out, b8.zhigh_out, b8.lo_in, b8.hi_in};
  assign o_strb    = sel8 ? s8 : s16;
  assign o_reg_in  = sel8 ? {8'h00, b8.reg_in}  : b16.reg_in;
  assign o_reg_out = sel8 ? {8'h00, b8.reg_out} : b16.reg_out;
  assign o_alu     = sel8 ? b8.alu_op  : b16.alu_op;
  assign o_busy    = sel8 ? b8.busy    : b16.busy;
  assign o_done    = sel8 ? b8.done    : b16.done;
  assign o_illegal = sel8 ? b8.illegal : b16.illegal;

  // Bus-driver exclusivity on both instances, every cycle.
  always @(negedge clk) begin
    if (int'(b16.pc_out) + int'(b16.mdr_out) + int'(b16.zlow_out) + int'(b16.zhigh_out) +
        $countones(b16.reg_out) > 1) viol++;
    if (int'(b8.pc_out) + int'(b8.mdr_out) + int'(b8.zlow_out) + int'(b8.zhigh_out) +
        $countones(b8.reg_out) > 1) viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        use8;
    logic [31:0] ir;
    int          waits;
    int          e_done, e_ill, e_wait;
    logic [15:0] e_ro_y, e_ro_z, e_ri;
    logic [4:0]  e_alu;
    int          e_lo, e_hi, e_ny, e_nz;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int w = v.waits;
    int d_cyc = 0, ill_cyc = 0, n_wait = 0, n_ir = 0, n_lo = 0, n_hi = 0, ny = 0, nz = 0, gaps = 0;
    logic [15:0] ro_y = '0, ro_z = '0, ri = '0;
    logic [4:0]  alu_z = '0;
    bit fin = 0;
    string p = $sformatf("v%0d_", idx);
    sel8 = v.use8; ir = v.ir; step_mode = 1'b1; mem_ready = 1'b0;
    @(negedge clk); run = 1'b1;
    for (int c = 1; c <= 30 && !fin; c++) begin
      @(negedge clk);
      run = 1'b0;
      if (!o_busy) gaps++;
      if (o_strb[9]) begin
        mem_ready = (w == 0);
        if (w > 0) w--;
        if (!o_strb[10]) n_wait++;
      end else begin
        mem_ready = 1'b0;
      end
      n_ir += int'(o_strb[6]);
      ny   += int'(o_strb[5]);
      nz   += int'(o_strb[4]);
      n_lo += int'(o_strb[1] & o_strb[3]);
      n_hi += int'(o_strb[0] & o_strb[2] & o_done);
      if (o_strb[5]) ro_y |= o_reg_out;
      if (o_strb[4] && !o_strb[13]) begin ro_z |= o_reg_out; alu_z = o_alu; end
      ri |= o_reg_in;
      if (o_done)    begin d_cyc = c;   fin = 1; end
      if (o_illegal) begin ill_cyc = c; fin = 1; end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check({p, "done_cyc"},  d_cyc,   v.e_done);
    check({p, "ill_cyc"},   ill_cyc, v.e_ill);
    check({p, "wait_cyc"},  n_wait,  v.e_wait);
    check({p, "ir_in_cnt"}, n_ir,    1);
    check({p, "rout_y"},    ro_y,    v.e_ro_y);
    check({p, "rout_z"},    ro_z,    v.e_ro_z);
    check({p, "alu_op"},    alu_z,   v.e_alu);
    check({p, "reg_in"},    ri,      v.e_ri);
    check({p, "lo_wb"},     n_lo,    v.e_lo);
    check({p, "hi_wb"},     n_hi,    v.e_hi);
    check({p, "y_in_cnt"},  ny,      v.e_ny);
    check({p, "z_in_cnt"},  nz,      v.e_nz);
    check({p, "busy_gap"},  gaps,    0);
    check({p, "idle_after"}, o_busy, 0);
  endtask

  initial begin
    int d1, d2, hit;
    logic t0_after;
    vecs[0] = '{1'b0, 32'h20228000, 0, 6, 0, 0, 16'h0010, 16'h0020, 16'h0001, 5'b00100, 0, 0, 1, 2};
    vecs[1] = '{1'b0, 32'h20228000, 3, 9, 0, 3, 16'h0010, 16'h0020, 16'h0001, 5'b00100, 0, 0, 1, 2};
    vecs[2] = '{1'b0, 32'h78118000, 0, 7, 0, 0, 16'h0004, 16'h0008, 16'h0000, 5'b01111, 1, 1, 1, 2};
    vecs[3] = '{1'b0, 32'hF8000000, 0, 0, 5, 0, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 1};
    vecs[4] = '{1'b0, 32'h1B890000, 0, 6, 0, 0, 16'h0002, 16'h0004, 16'h0080, 5'b00011, 0, 0, 1, 2};
    vecs[5] = '{1'b0, 32'h31998000, 1, 7, 0, 1, 16'h0008, 16'h0008, 16'h0008, 5'b00110, 0, 0, 1, 2};
    vecs[6] = '{1'b1, 32'h87B30000, 0, 7, 0, 0, 16'h0040, 16'h0040, 16'h0000, 5'b10000, 1, 1, 1, 2};
    vecs[7] = '{1'b1, 32'h20278000, 0, 0, 5, 0, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 1};
    vecs[8] = '{1'b1, 32'h2C888000, 0, 0, 5, 0, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 1};

    clr = 1'b0; run = 1'b0; step_mode = 1'b1; mem_ready = 1'b0; sel8 = 1'b0; ir = 32'h20228000;
    #12;
    check("reset_outs16", {s16, b16.reg_in, b16.reg_out, b16.alu_op, b16.busy, b16.done, b16.illegal}, 0);
    check("reset_outs8",  {s8, b8.reg_in, b8.reg_out, b8.alu_op, b8.busy, b8.done, b8.illegal}, 0);
    @(negedge clk); clr = 1'b1;
    hit = 0;
    repeat (3) begin @(negedge clk); hit += int'(b16.busy) + int'(b8.busy); end
    check("idle_hold", hit, 0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-to-back SUBs with step_mode low; switch to step mode during the second one.
    sel8 = 1'b0; ir = 32'h20228000; step_mode = 1'b0; mem_ready = 1'b1;
    d1 = 0; d2 = 0; t0_after = 1'b0;
    @(negedge clk); run = 1'b1;
    for (int c = 1; c <= 30 && d2 == 0; c++) begin
      @(negedge clk);
      run = 1'b0;
      if (d1 != 0 && c == d1 + 1) begin t0_after = o_strb[13]; step_mode = 1'b1; end
      if (o_done) begin if (d1 == 0) d1 = c; else d2 = c; end
    end
    @(negedge clk);
    check("cont_first_done", d1, 6);
    check("cont_done_gap", d2 - d1, 6);
    check("cont_t0_follows", t0_after, 1);
    check("cont_idle_after", o_busy, 0);
    mem_ready = 1'b0;

    // Reset asserted mid-cycle while in T4.
    sel8 = 1'b0; ir = 32'h20228000; step_mode = 1'b1; mem_ready = 1'b1; hit = 0;
    @(negedge clk); run = 1'b1;
    for (int c = 1; c <= 20 && hit == 0; c++) begin
      @(negedge clk);
      run = 1'b0;
      if (o_strb[4] && !o_strb[13]) hit = 1;
    end
    check("rst_reached_t4", hit, 1);
    #2 clr = 1'b0;
    #1;
    check("rst_outs_zero", {s16, b16.reg_in, b16.reg_out, b16.alu_op, b16.done, b16.illegal}, 0);
    check("rst_busy", b16.busy, 0);
    @(negedge clk); @(negedge clk); clr = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {s16, b16.busy, b16.done}, 0);
    mem_ready = 1'b0;
    run_vec(9, vecs[0]);

    check("one_driver", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
